// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits plus odd parity, check device ACK.
// Ports: clk/reset, tx_data/tx_valid/tx_ready handshake, busy/tx_done/tx_error status, raw pads in, pull-low enables out.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 420,
  parameter int START_TIMEOUT  = 52500,
  parameter int BIT_TIMEOUT    = 1400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TW =
    $clog2(START_TIMEOUT + BIT_TIMEOUT + INHIBIT_CYCLES + 1);

  // ABORT and the error cycle consume the last two counts, so the
  // tx_error pulse lands exactly on the timeout distance from its
  // reference (START entry, or the detected fall).
  localparam logic [TW-1:0] INH_END   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_END = TW'(START_TIMEOUT - 2);
  localparam logic [TW-1:0] BIT_END   = TW'(BIT_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, START, XFER, ACK, WAIT_IDLE, ABORT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    cnt, cnt_n;
  logic [8:0]    shift, shift_n;
  logic          dat_q, dat_n;
  logic          done_q, done_n;
  logic          err_q, err_n;

  logic clk_s1, clk_s2, clk_d;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_d & ~clk_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      cnt    <= '0;
      shift  <= '0;
      dat_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      dat_q  <= dat_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    cnt_n   = cnt;
    shift_n = shift;
    dat_n   = dat_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        dat_n   = 1'b0;
        if (tx_valid) begin
          shift_n = {~^tx_data, tx_data};
          cnt_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer == INH_END) begin
          dat_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        timer_n = '0;
        state_n = START;
      end
      START: begin
        if (fall) begin
          dat_n   = ~shift[0];
          shift_n = shift >> 1;
          cnt_n   = 4'd1;
          timer_n = TW'(1);
          state_n = XFER;
        end else if (timer == START_END) begin
          state_n = ABORT;
        end
      end
      XFER: begin
        if (fall) begin
          cnt_n   = cnt + 4'd1;
          timer_n = TW'(1);
          if (cnt == 4'd9) begin
            dat_n   = 1'b0;
            state_n = ACK;
          end else begin
            dat_n   = ~shift[0];
            shift_n = shift >> 1;
          end
        end else if (timer == BIT_END) begin
          state_n = ABORT;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_n   = cnt + 4'd1;
          timer_n = TW'(1);
          state_n = dat_s2 ? ABORT : WAIT_IDLE;
        end else if (timer == BIT_END) begin
          state_n = ABORT;
        end
      end
      WAIT_IDLE: begin
        if ((clk_s2 && dat_s2) || timer == BIT_END) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      ABORT: begin
        dat_n   = 1'b0;
        err_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
  // DAT is only ever pulled while a frame is being driven.
  assign ps2_dat_oe = dat_q &&
    ((state == REQ) || (state == START) || (state == XFER));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, 12.5 kHz device clocking model,
// outcome scoreboard and wire-frame checks.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int IC   = 420;
  localparam int ST   = 52500;
  localparam int BT   = 1400;
  localparam int HALF = 140;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #143 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         nedges;
    bit         ack;
    bit         chk;
    logic [9:0] frame;
  } dev_t;

  // kind: 0 no timing, 1 delay from START entry, 2 from last device fall
  typedef struct {
    bit err;
    int kind;
    int delay;
  } out_t;

  dev_t dev_q[$];
  out_t out_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int last_fall = 0;
  int last_done = 0;
  int dev_edges = 0;
  bit dev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dev_push(input int n, input bit ack, input bit c,
                          input logic [9:0] f);
    dev_t d;
    d.nedges = n;
    d.ack = ack;
    d.chk = c;
    d.frame = f;
    dev_q.push_back(d);
  endtask

  task automatic out_push(input bit err, input int kind, input int dly);
    out_t o;
    o.err = err;
    o.kind = kind;
    o.delay = dly;
    out_q.push_back(o);
  endtask

  task automatic accept(input logic [7:0] d, output int acc);
    int n;
    n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin
      tick(1);
      n++;
    end
    chk("accept_bound", int'(n < 20000), 1);
    tick(1);
    acc = cyc - 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_q.size() != 0 || dev_busy) && n < 60000) begin
      tick(1);
      n++;
    end
    chk("wait_bound", int'(n < 60000), 1);
    tick(20);
  endtask

  // Device: reacts to the host releasing CLK while holding the start bit.
  initial begin
    dev_t c;
    logic [9:0] cap;
    forever begin
      @(negedge ps2_clk_oe);
      if (ps2_dat_oe && dev_q.size() != 0) begin
        c = dev_q.pop_front();
        dev_busy = 1'b1;
        cap = '0;
        tick(100);
        for (int e = 1; e <= c.nedges; e++) begin
          dev_clk = 1'b0;
          dev_edges++;
          last_fall = cyc;
          tick(HALF);
          if (e <= 10) cap[e-1] = ps2_dat_in;
          dev_clk = 1'b1;
          if (e == 10) dev_dat = c.ack ? 1'b0 : 1'b1;
          tick(HALF);
        end
        dev_dat = 1'b1;
        if (c.chk) chk("wire_frame", int'(cap), int'(c.frame));
        dev_busy = 1'b0;
      end
    end
  end

  // Monitor: phase lengths and done/error outcomes.
  initial begin
    int   inh;
    int   req;
    int   start_cyc;
    bit   pclk;
    out_t o;
    inh = 0;
    req = 0;
    start_cyc = 0;
    pclk = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inh = 0;
        req = 0;
        pclk = 1'b0;
      end else begin
        if (ps2_clk_oe && !ps2_dat_oe) inh++;
        if (ps2_clk_oe && ps2_dat_oe) req++;
        if (pclk && !ps2_clk_oe) begin
          chk("inhibit_len", inh, IC);
          chk("req_len", req, 1);
          start_cyc = cyc;
          inh = 0;
          req = 0;
        end
        pclk = ps2_clk_oe;
        if (tx_done || tx_error) begin
          chk("done_err_excl", int'(tx_done && tx_error), 0);
          chk("ready_at_pulse", int'(tx_ready), 1);
          chk("lines_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
          chk("pulse_expected", int'(out_q.size() != 0), 1);
          if (tx_done) last_done = cyc;
          if (out_q.size() != 0) begin
            o = out_q.pop_front();
            chk("outcome_err", int'(tx_error), int'(o.err));
            if (o.kind == 1)
              chk("start_timeout_dly", cyc - start_cyc, o.delay);
            if (o.kind == 2)
              chk("bit_timeout_dly", cyc - last_fall, o.delay);
          end
        end
      end
    end
  end

  initial begin
    int acc;
    int n;
    tick(3);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_error", int'(tx_error), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_dat_oe", int'(ps2_dat_oe), 0);
    reset = 1'b0;
    tick(5);

    // 0xED: six ones, parity 1
    dev_push(11, 1'b1, 1'b1, 10'h3ED);
    out_push(1'b0, 0, 0);
    accept(8'hED, acc);
    tx_valid = 1'b0;
    wait_idle();

    // back-to-back 0x01 (parity 0) then 0x00 (parity 1), valid held
    dev_push(11, 1'b1, 1'b1, 10'h201);
    dev_push(11, 1'b1, 1'b1, 10'h300);
    out_push(1'b0, 0, 0);
    out_push(1'b0, 0, 0);
    accept(8'h01, acc);
    accept(8'h00, acc);
    chk("b2b_accept_cycle", acc, last_done);
    tx_valid = 1'b0;
    wait_idle();

    // NACK on 0xF4 (five ones, parity 0)
    dev_push(11, 1'b0, 1'b1, 10'h2F4);
    out_push(1'b1, 0, 0);
    accept(8'hF4, acc);
    tx_valid = 1'b0;
    wait_idle();

    // device never clocks
    dev_push(0, 1'b1, 1'b0, 10'h000);
    out_push(1'b1, 1, ST);
    accept(8'h55, acc);
    tx_valid = 1'b0;
    wait_idle();

    // device stops after edge 5; fall is seen 2 cycles after the pad drops
    dev_push(5, 1'b1, 1'b0, 10'h000);
    out_push(1'b1, 2, BT + 2);
    accept(8'hAA, acc);
    tx_valid = 1'b0;
    wait_idle();

    // reset after edge 4
    dev_edges = 0;
    dev_push(4, 1'b1, 1'b0, 10'h000);
    accept(8'h3C, acc);
    tx_valid = 1'b0;
    n = 0;
    while (dev_edges < 4 && n < 20000) begin
      tick(1);
      n++;
    end
    chk("edge4_bound", int'(n < 20000), 1);
    tick(10);
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("mid_rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pulse", int'({tx_done, tx_error}), 0);
    reset = 1'b0;
    n = 0;
    while (dev_busy && n < 20000) begin
      tick(1);
      n++;
    end
    chk("dev_idle_bound", int'(n < 20000), 1);
    tick(20);

    // 0xFF: eight ones, parity 1
    dev_push(11, 1'b1, 1'b1, 10'h3FF);
    out_push(1'b0, 0, 0);
    accept(8'hFF, acc);
    tx_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
